// File: rtl/edit_btn_repeater.sv
// Turns the debounced hours/minutes edit-button levels into single-cycle increment
// pulses: one on press, then auto-repeat while held; a two-button chord locks editing out.
module edit_btn_repeater #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] btn_lvl,
    output logic [1:0] edit_pulse,
    output logic       editing
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             sel_r;
    logic             sel_s;
    logic [1:0]       pulse_s;
    logic             editing_s;

    // Next-state, shared counter and pulse decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sel_s   = sel_r;
        pulse_s = 2'b00;
        if (!enable) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    case (btn_lvl)
                        2'b01: begin
                            state_s = PRESS;
                            sel_s   = 1'b0;
                            pulse_s = 2'b01;
                            cnt_s   = HOLD_LOAD;
                        end
                        2'b10: begin
                            state_s = PRESS;
                            sel_s   = 1'b1;
                            pulse_s = 2'b10;
                            cnt_s   = HOLD_LOAD;
                        end
                        2'b11: begin
                            state_s = LOCK;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end
                PRESS, REPEAT: begin
                    // Release is checked first so it beats a repeat falling due on the same edge
                    if (!btn_lvl[sel_r]) begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                    end else if (btn_lvl[~sel_r]) begin
                        state_s = LOCK;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_s = REPEAT;
                        pulse_s = sel_r ? 2'b10 : 2'b01;
                        cnt_s   = REPEAT_LOAD;
                    end else begin
                        cnt_s   = cnt_r - CNT_ONE;
                    end
                end
                LOCK: begin
                    if (btn_lvl == 2'b00) begin
                        state_s = IDLE;
                    end else begin
                        state_s = LOCK;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
        editing_s = (state_s == PRESS) || (state_s == REPEAT);
    end

    // State, counter, channel select and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            sel_r      <= 1'b0;
            edit_pulse <= 2'b00;
            editing    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            sel_r      <= sel_s;
            edit_pulse <= pulse_s;
            editing    <= editing_s;
        end
    end

endmodule
